// File: rtl/pal_seq_if.sv
// Configuration and logic bus of the second-generation PAL.
// The PAL itself takes the slave side; whatever drives config and inputs takes the master side.
interface pal_seq_if #(
  parameter int N = 4,
  parameter int M = 1
);
  logic         CFG_EN;
  logic         CFG;
  logic         CFG_OUT;
  logic         CFG_DONE;
  logic [N-1:0] INPUT_VARS;
  logic [M-1:0] OUTPUT_VALS;

  modport master (
    output CFG_EN, CFG, INPUT_VARS,
    input  CFG_OUT, CFG_DONE, OUTPUT_VALS
  );

  modport slave (
    input  CFG_EN, CFG, INPUT_VARS,
    output CFG_OUT, CFG_DONE, OUTPUT_VALS
  );
endinterface

// File: rtl/pal_seq.sv
// Parametrised PAL: serially loaded AND/OR planes, per-output registered or
// combinational macrocells, and outputs held at zero until a full load completes.
module pal_seq #(
  parameter int N = 4,
  parameter int M = 1,
  parameter int P = 3
) (
  input  logic      CLK,
  input  logic      RST,
  pal_seq_if.slave  bus
);
  localparam int L  = 2*N*P + P*M + M;
  localparam int A  = 2*N*P;
  localparam int CW = $clog2(L+1);
  localparam logic [CW-1:0] L_CNT = CW'(L);

  logic [L-1:0]  r_cfg;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [M-1:0]  r_out;

  logic [P-1:0]  w_term;
  logic [M-1:0]  w_comb;
  logic [M-1:0]  w_mode;

  genvar gi, gj;

  // A term with no literal selected must read 0, so "any literal used" gates the AND.
  generate
    for (gi = 0; gi < P; gi++) begin : g_term
      logic [N-1:0] w_used;
      logic [N-1:0] w_lit_ok;
      for (gj = 0; gj < N; gj++) begin : g_lit
        assign w_used[gj]   = r_cfg[2*N*gi + 2*gj] | r_cfg[2*N*gi + 2*gj + 1];
        assign w_lit_ok[gj] = (~r_cfg[2*N*gi + 2*gj]     |  bus.INPUT_VARS[gj]) &
                              (~r_cfg[2*N*gi + 2*gj + 1] | ~bus.INPUT_VARS[gj]);
      end
      assign w_term[gi] = (|w_used) & (&w_lit_ok);
    end

    for (gi = 0; gi < M; gi++) begin : g_out
      assign w_comb[gi] = |(w_term & r_cfg[A + gi*P +: P]);
      assign w_mode[gi] = r_cfg[A + P*M + gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cfg  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_out  <= '0;
    end else begin
      r_out <= r_done ? w_comb : '0;
      if (bus.CFG_EN) begin
        r_cfg <= {bus.CFG, r_cfg[L-1:1]};
        // A shift while loaded starts a fresh load; this bit is its first.
        if (r_done) begin
          r_done <= 1'b0;
          r_cnt  <= CW'(1);
        end else if (r_cnt != L_CNT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_cnt == L_CNT) begin
        r_done <= 1'b1;
      end
    end
  end

  assign bus.CFG_OUT     = r_cfg[0];
  assign bus.CFG_DONE    = r_done;
  assign bus.OUTPUT_VALS = r_done ? ((w_mode & r_out) | (~w_mode & w_comb)) : '0;
endmodule

// File: tb/tb_pal_seq.sv
// Randomised bench for pal_seq: a stimulus process pushes predicted outputs into a
// scoreboard queue and a negedge monitor pops and compares them against the DUT.
module tb_pal_seq;
  localparam int N = 4;
  localparam int M = 1;
  localparam int P = 3;
  localparam int L = 2*N*P + P*M + M;
  localparam int A = 2*N*P;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pal_seq_if #(.N(N), .M(M)) bus ();
  pal_seq #(.N(N), .M(M), .P(P)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    logic         co;
    logic         dn;
    logic [M-1:0] ov;
    int           n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Reference model: cfg is simply the last L bits shifted in since reset.
  bit           q_bits[$];
  int           m_cnt = 0;
  bit           m_done = 1'b0;
  logic [M-1:0] m_out = '0;

  function automatic bit cfg_bit(int k);
    int idx;
    idx = q_bits.size() - L + k;
    return (idx >= 0) ? q_bits[idx] : 1'b0;
  endfunction

  function automatic logic [M-1:0] comb_of(logic [N-1:0] v);
    logic [M-1:0] r;
    r = '0;
    for (int o = 0; o < M; o++)
      for (int p = 0; p < P; p++)
        if (cfg_bit(A + o*P + p)) begin
          bit any;
          bit ok;
          any = 1'b0;
          ok  = 1'b1;
          for (int i = 0; i < N; i++) begin
            bit t;
            bit c;
            t = cfg_bit(2*N*p + 2*i);
            c = cfg_bit(2*N*p + 2*i + 1);
            if (t || c) any = 1'b1;
            if (t && !v[i]) ok = 1'b0;
            if (c && v[i])  ok = 1'b0;
          end
          if (any && ok) r[o] = 1'b1;
        end
    return r;
  endfunction

  function automatic logic [M-1:0] expected_out(logic [N-1:0] v);
    logic [M-1:0] c;
    logic [M-1:0] r;
    c = comb_of(v);
    r = '0;
    if (m_done)
      for (int o = 0; o < M; o++)
        r[o] = cfg_bit(A + P*M + o) ? m_out[o] : c[o];
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic b, input logic [N-1:0] v);
    if (r) begin
      q_bits.delete();
      m_cnt  = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      m_out = m_done ? comb_of(v) : '0;
      if (e) begin
        q_bits.push_back(b);
        if (q_bits.size() > L) void'(q_bits.pop_front());
        if (m_done) begin
          m_done = 1'b0;
          m_cnt  = 1;
        end else if (m_cnt < L) begin
          m_cnt++;
        end
      end else if (m_cnt == L) begin
        m_done = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive inputs, predict what the DUT shows during this cycle, step the model.
  task automatic cyc(input logic r, input logic e, input logic b, input logic [N-1:0] v);
    exp_t x;
    rst            = r;
    bus.CFG_EN     = e;
    bus.CFG        = b;
    bus.INPUT_VARS = v;
    x.co = cfg_bit(0);
    x.dn = m_done;
    x.ov = expected_out(v);
    x.n  = cyc_no;
    sb.push_back(x);
    @(posedge clk);
    model_edge(r, e, b, v);
    cyc_no++;
    #1;
  endtask

  function automatic logic [N-1:0] rv();
    return N'($urandom);
  endfunction

  task automatic shift_bits(input logic [L-1:0] c, input int from, input int to);
    for (int k = from; k < to; k++) cyc(1'b0, 1'b1, c[k], rv());
  endtask

  task automatic load(input logic [L-1:0] c);
    shift_bits(c, 0, L);
    cyc(1'b0, 1'b0, 1'b0, rv());
  endtask

  // At most one literal per input, so random terms are usually satisfiable.
  function automatic logic [L-1:0] friendly_cfg();
    logic [L-1:0] c;
    c = '0;
    for (int p = 0; p < P; p++)
      for (int i = 0; i < N; i++)
        case ($urandom_range(0, 3))
          0: c[2*N*p + 2*i]     = 1'b1;
          1: c[2*N*p + 2*i + 1] = 1'b1;
          default: ;
        endcase
    for (int k = A; k < L; k++) c[k] = 1'($urandom);
    return c;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp += 3;
      if (bus.CFG_OUT !== e.co) begin
        n_bad++;
        $display("FAIL cfg_out cyc %0d: got %b want %b", e.n, bus.CFG_OUT, e.co);
      end
      if (bus.CFG_DONE !== e.dn) begin
        n_bad++;
        $display("FAIL cfg_done cyc %0d: got %b want %b", e.n, bus.CFG_DONE, e.dn);
      end
      if (bus.OUTPUT_VALS !== e.ov) begin
        n_bad++;
        $display("FAIL output_vals cyc %0d vars %b: got %b want %b", e.n, bus.INPUT_VARS, bus.OUTPUT_VALS, e.ov);
      end
    end
  end

  initial begin
    logic [L-1:0] c_comb;
    logic [L-1:0] c_reg;
    logic [L-1:0] c_sop;
    logic [L-1:0] c_rnd;
    int len;

    c_comb = '0; c_comb[0] = 1'b1; c_comb[2] = 1'b1; c_comb[24] = 1'b1;
    c_reg  = c_comb; c_reg[27] = 1'b1;
    c_sop  = '0; c_sop[0] = 1'b1; c_sop[3] = 1'b1; c_sop[14] = 1'b1;
    c_sop[24] = 1'b1; c_sop[25] = 1'b1;

    rst = 1'b1; bus.CFG_EN = 1'b0; bus.CFG = 1'b0; bus.INPUT_VARS = '0;
    @(posedge clk); #1;

    cyc(1'b1, 1'b0, 1'b0, rv());
    cyc(1'b1, 1'b0, 1'b0, rv());
    repeat (5) cyc(1'b0, 1'b0, 1'b0, rv());

    load(c_comb);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 1'b0, 4'b1111);

    load(c_reg);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);

    load(c_sop);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);

    // Short load, pause, resume.
    shift_bits(c_comb, 0, 20);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, rv());
    shift_bits(c_comb, 20, L);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, rv());

    // Overshoot: two leading junk bits must exit on CFG_OUT.
    cyc(1'b0, 1'b1, 1'b1, rv());
    cyc(1'b0, 1'b1, 1'b0, rv());
    load(c_reg);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, rv());

    // Reset mid-load, then a clean load.
    shift_bits(c_sop, 0, 10);
    cyc(1'b1, 1'b0, 1'b0, rv());
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    load(c_comb);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);

    // Reset while loaded in registered mode.
    load(c_reg);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);
    cyc(1'b1, 1'b0, 1'b0, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0: cyc(1'b1, 1'b0, 1'b0, rv());
        1, 2: begin
          len = $urandom_range(1, L + 4);
          for (int k = 0; k < len; k++) cyc(1'b0, 1'b1, 1'($urandom), rv());
        end
        default: begin
          c_rnd = friendly_cfg();
          shift_bits(c_rnd, 0, L);
        end
      endcase
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) cyc(1'b0, 1'b0, 1'b0, rv());
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pal_seq.md
Name: pal_seq

Overview:
Second-generation parametrised PAL. Programmable AND plane (N inputs, true/complement literals, P product terms) and OR plane (M outputs), configured via a bit-serial shift chain. Adds over the first generation:
- Explicit load enable and a load-complete flag.
- Daisy-chain shift-out.
- Per-output registered/combinational macrocell mode.
- Synchronous reset.
- Outputs gated until configuration is complete.

Parameters:
N, 4, number of input variables
M, 1, number of outputs
P, 3, number of product terms
L (localparam), 2*N*P + P*M + M, configuration chain length

Ports:
CLK  input  1  single system clock, also shifts config
RST  input  1  synchronous, active-high reset
CFG_EN  input  1  config shift enable
CFG  input  1  serial config data in
CFG_OUT  output  1  serial config data out (cfg[0]), for daisy-chaining
CFG_DONE  output  1  registered; 1 = valid configuration loaded
INPUT_VARS  input  N  logic inputs
OUTPUT_VALS  output  M  logic outputs

Behaviour:
- State: cfg[L-1:0], bit counter cnt (0..L, saturating), done flag, out_reg[M-1:0].
- Reset: RST high at a CLK edge clears cfg=0, cnt=0, done=0, out_reg=0. Outputs after reset: CFG_DONE=0, CFG_OUT=0, OUTPUT_VALS=0.
- RST has priority over every other event. Reset mid-load aborts the load; the next load starts from cnt=0.
- Shift: on each CLK edge with CFG_EN=1, cfg <= {CFG, cfg[L-1:1]} and cnt <= min(cnt+1, L). The first bit sent lands in cfg[0] after L shifts.
- Overshoot: shifting continues past L; cnt stays at L, and excess bits exit via CFG_OUT.
- Starting a new load: a CFG_EN=1 edge while done=1 sets done<=0 and cnt<=1, and shifts that bit.
- Completing a load: a CFG_EN=0 edge with cnt==L sets done<=1.
- Short load: CFG_EN dropping with cnt<L leaves done=0 and cnt holds. Reasserting CFG_EN resumes counting.
- CFG_EN=0 with done=1: cfg is frozen.
- Field map, with A = 2*N*P:
  - cfg[2*N*p + 2*i] = term p includes INPUT_VARS[i].
  - cfg[2*N*p + 2*i + 1] = term p includes ~INPUT_VARS[i].
  - cfg[A + o*P + p] = output o ORs in term p.
  - cfg[A + P*M + o] = output o mode: 1 = registered, 0 = combinational.
- Term p = AND of its selected literals. A term with no literal selected = 0. Both literals of one input selected gives a term that is always 0.
- comb[o] = OR of its connected terms; 0 if no term is connected.
- out_reg[o] <= done ? comb[o] : 0 on every non-reset edge.
- OUTPUT_VALS[o] = !done ? 0 : (mode[o] ? out_reg[o] : comb[o]).
- Latency: combinational mode = same cycle. Registered mode = value visible after the next CLK edge. The first registered value after done rises appears one edge after done.
- During reload (done=0), OUTPUT_VALS=0 and the partially shifted cfg has no effect.

Test Plan:
- Defaults (N=4, M=1, P=3, L=28):
  - Reset, then hold CFG_EN=0 for 5 cycles -> CFG_DONE=0 and OUTPUT_VALS=0 for any INPUT_VARS.
- Combinational load:
  - Shift 28 bits, cfg[0]=1, cfg[2]=1, cfg[24]=1, all others 0 (term0 = I0&I1, mode 0). Drop CFG_EN.
  - Required: CFG_DONE=1 one edge later. INPUT_VARS=4'b0011 -> OUTPUT_VALS=1 in the same cycle. 4'b0001 -> 0. 4'b1111 -> 1.
- Registered mode:
  - Same stream plus cfg[27]=1. Apply 4'b0011 -> OUTPUT_VALS=0 until the next edge, then 1. Apply 4'b0000 -> stays 1 for one edge, then 0.
- Sum of products and complement literals:
  - Term0 = I0&~I1 (cfg[0], cfg[3]), term1 = I3 (cfg[14]). OR bits cfg[24], cfg[25] set.
  - Required: 4'b0001 -> 1, 4'b1000 -> 1, 4'b0011 -> 0, 4'b0000 -> 0.
- Short load and overshoot:
  - Drop CFG_EN after 20 bits -> CFG_DONE stays 0. Resume for 8 bits -> CFG_DONE=1.
  - Reload with 30 bits: the first 2 bits sent appear on CFG_OUT on shifts 29 and 30. The final cfg equals the last 28 bits sent.
- Reset mid-operation:
  - Assert RST at shift 10 of a load -> CFG_DONE=0 and OUTPUT_VALS=0. A full subsequent 28-bit load then works per the combinational-load case.
  - Assert RST while done in registered mode -> OUTPUT_VALS=0 on the next edge.
